// File: rtl/inst_fetcher_pkg.sv
// Shared constants for the fetch front end: opcodes, bus width, queue entry
// layout and the next-fetch-address rule.
package inst_fetcher_pkg;

    localparam int DATA_BUS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Queue entry packs {pc, inst, taken}, pc in the top bits.
    localparam int ENTRY_W = 2 * DATA_BUS + 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_t;

    function automatic logic [DATA_BUS-1:0] j_imm(input logic [DATA_BUS-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [DATA_BUS-1:0] b_imm(input logic [DATA_BUS-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // JALR targets depend on a register value, so fetch simply falls through.
    function automatic logic [DATA_BUS-1:0] next_fetch_pc(
        input logic [DATA_BUS-1:0] pc,
        input logic [DATA_BUS-1:0] inst,
        input logic                taken
    );
        logic [DATA_BUS-1:0] nxt;
        nxt = pc + 32'd4;
        case (inst[6:0])
            OPC_JAL:    nxt = pc + j_imm(inst);
            OPC_BRANCH: nxt = taken ? pc + b_imm(inst) : pc + 32'd4;
            OPC_JALR:   nxt = pc + 32'd4;
            default:    nxt = pc + 32'd4;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue with push, pop and flush; the head entry is
// presented combinationally.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (en && !rst && !flush && do_push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + 1'b1;
                end
                if (do_pop) begin
                    head <= head + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch unit: one outstanding memory request at a time, static
// next-PC prediction, results buffered in inst_queue for the decoder.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        Inst_Ready,
    output logic        Pred_Taken,
    input  logic        received,
    input  logic        clr,
    input  logic [31:0] clr_pc,
    output logic [31:0] pred_pc,
    input  logic        pred_taken,
    output logic        fetch_state
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_t         state;
    logic [DATA_BUS-1:0]  fetch_pc;
    logic                 discard;
    logic [CNT_W-1:0]     count;
    logic [ENTRY_W-1:0]   head_data;
    logic [ENTRY_W-1:0]   push_data;
    logic                 push;
    logic                 taken;

    // A response is kept only if it is neither stale nor hit by a flush.
    assign push        = (state == WAIT_MEM) && mem_ready && !discard && !clr;
    assign taken       = (mem_data[6:0] == OPC_BRANCH) && pred_taken;
    assign push_data   = {fetch_pc, mem_data, taken};
    assign pred_pc     = fetch_pc;
    assign fetch_state = state;

    assign PC         = head_data[ENTRY_W-1 -: DATA_BUS];
    assign Inst       = head_data[DATA_BUS:1];
    assign Pred_Taken = head_data[0];
    assign Inst_Ready = (count != '0);

    inst_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (clr),
        .push      (push),
        .push_data (push_data),
        .pop       (received),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else if (rdy) begin
            if (clr) begin
                fetch_pc <= clr_pc;
            end
            case (state)
                IDLE: begin
                    // The slot for the response is reserved here, so it always fits.
                    if (!clr && (count < CNT_W'(IQ_DEPTH))) begin
                        state    <= WAIT_MEM;
                        mem_req  <= 1'b1;
                        mem_addr <= {fetch_pc[31:2], 2'b00};
                    end
                end
                WAIT_MEM: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        if (!discard && !clr) begin
                            fetch_pc <= next_fetch_pc(fetch_pc, mem_data, pred_taken);
                        end
                    end else if (clr) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4: instruction queue entries, power of two.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global ready; low freezes all state.
REQ-006 mem_req  out  1  fetch request; held high until mem_ready.
REQ-007 mem_addr  out  32  word-aligned fetch address; stable while mem_req is high.
REQ-008 mem_ready  in  1  one-cycle pulse; mem_data valid this cycle.
REQ-009 mem_data  in  32  returned instruction word.
REQ-010 PC  out  32  PC of the queue head.
REQ-011 Inst  out  32  instruction at the queue head.
REQ-012 Inst_Ready  out  1  queue head valid.
REQ-013 Pred_Taken  out  1  prediction recorded for the head branch.
REQ-014 received  in  1  decoder consumed the head this cycle.
REQ-015 clr  in  1  flush and redirect.
REQ-016 clr_pc  in  32  redirect target, valid with clr.
REQ-017 pred_pc  out  32  branch PC sent to the predictor, combinational.
REQ-018 pred_taken  in  1  predictor answer for pred_pc, same cycle.

Function
REQ-019 FSM SHALL use two states: IDLE, WAIT_MEM.
- IDLE -> WAIT_MEM when (count + 0) < IQ_DEPTH and no clr; mem_req=1, mem_addr=fetch_pc.
- WAIT_MEM -> IDLE on mem_ready.
REQ-020 SHALL keep at most one request outstanding; a slot is reserved at request time, so a response never finds the queue full.
REQ-021 On mem_ready with no discard pending, SHALL push {fetch_pc, mem_data, taken} at the tail in the same edge.
REQ-022 Next fetch_pc SHALL be:
- opcode 1101111 (JAL): pc + sext(J-imm).
- opcode 1100011 (branch): pred_taken ? pc + sext(B-imm) : pc+4, with pred_pc=fetch_pc.
- otherwise: pc+4, including JALR.
REQ-023 All PC arithmetic SHALL be 32-bit modulo 2^32; wrap is silent.
REQ-024 Inst_Ready SHALL equal (count != 0); PC/Inst/Pred_Taken SHALL show the head entry combinationally.
REQ-025 A pop SHALL occur when received && Inst_Ready; received with an empty queue SHALL be ignored.
REQ-026 A push and a pop on the same edge SHALL leave count unchanged; head and tail pointers wrap modulo IQ_DEPTH.
REQ-027 On clr, on the next edge the block SHALL:
- empty the queue;
- set fetch_pc = clr_pc;
- ignore pushes and pops in that cycle.
REQ-028 clr in WAIT_MEM SHALL keep mem_req/mem_addr unchanged and set discard; the matching mem_ready SHALL be dropped, then a fetch to clr_pc SHALL issue.
REQ-029 clr coinciding with mem_ready SHALL drop that response with no discard left pending.
REQ-030 With rdy low, SHALL hold all registers; outputs unchanged, no push/pop.

Reset
REQ-031 On rst, the next edge SHALL set:
- fetch_pc=RESET_PC, count=0, pointers=0;
- state=IDLE, mem_req=0, discard=0, Inst_Ready=0.
Reset overrides clr and rdy.
REQ-032 rst mid-WAIT_MEM SHALL drop the outstanding request; the memory controller is reset by the same rst.

Structure
REQ-033 Opcode constants (JAL 1101111, branch 1100011, JALR 1100111) SHALL come from the shared constants package alongside the decoder opcodes; `Data_Bus width SHALL be reused.
REQ-034 The queue SHALL be one sub-module, inst_queue (push/pop/flush, count, head data).

Verification
REQ-035 Reset, then memory returns 00000013 per request at 0,4,8,12 with received=0 -> four entries, mem_req stays 0 after fourth push, Inst_Ready=1, PC=0.
REQ-036 Full queue, received=1 for one cycle -> head PC=4, count=3, new request to addr 16 next cycle.
REQ-037 At PC 0x100, JAL +0x20 returned -> next mem_addr=0x120.
REQ-038 At PC 0x200, branch -8 with pred_taken=1 -> next mem_addr=0x1F8, Pred_Taken=1 at head; with pred_taken=0 -> 0x204.
REQ-039 clr with clr_pc=0x400 while WAIT_MEM on 0x40 -> Inst_Ready=0 next cycle, response for 0x40 dropped, following mem_addr=0x400.
REQ-040 rdy=0 for 3 cycles during mem_ready-free WAIT_MEM with received=1 -> count, PC, mem_addr unchanged throughout.
